// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush controller for the five-stage miniRV core.
// Bus-wait timeout FSM locks the pipeline on a hung access; saturating perf counters.
module hazard_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             load_use_hazard,
    input  logic             branch_taken_EX,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic             bus_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        state;
    logic [WW-1:0] waitCnt;
    logic          miss;
    logic          errState;
    logic          mStall;
    logic          br;
    logic          lu;

    // Reset masks ERR so outputs follow the RUN equations while cpu_rst is held.
    always_comb begin
        miss     = mem_req & ~mem_ready;
        errState = (state == ERR) & ~cpu_rst;
        mStall   = miss | errState;
        br       = branch_taken_EX & ~mStall;
        lu       = load_use_hazard & ~branch_taken_EX & ~mStall;

        ex_mem_stall = mStall;
        id_ex_stall  = mStall;
        mem_wb_flush = mStall;
        pc_stall     = mStall | lu;
        if_id_stall  = mStall | lu;
        if_id_flush  = br;
        id_ex_flush  = br | lu;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state     <= RUN;
            waitCnt   <= '0;
            bus_error <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_id_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);

            case (state)
                RUN: begin
                    if (miss) begin
                        state   <= WAIT;
                        waitCnt <= WW'(1);
                    end
                end
                WAIT: begin
                    if (!mem_req || mem_ready) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end else if (waitCnt == W_LAST) begin
                        state     <= ERR;
                        bus_error <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + WW'(1);
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state   <= RUN;
                    waitCnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline stall/flush controller for the five-stage miniRV core. It consumes the load-use hazard flag from data hazard detection, the EX-stage branch/jump redirect, and the MEM-stage bus handshake. From these it drives per-stage stall/flush enables for the PC and pipeline registers. It also owns a bus-wait timeout FSM that locks the pipeline on a hung access, plus saturating stall/flush performance counters.

## Interface
- TIMEOUT, 15, max consecutive MEM wait cycles before bus error; legal range ≥ 2
- CNT_W, 32, performance counter width
- cpu_clk  in  1  clock; all state on rising edge
- cpu_rst  in  1  reset, synchronous, active-high
- load_use_hazard  in  1  load in EX feeds instruction in ID
- branch_taken_EX  in  1  EX redirects PC (taken branch / jal / jalr)
- mem_req  in  1  MEM stage holds a load/store needing the bus
- mem_ready  in  1  bus completes the MEM access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  clear ID/EX to bubble
- ex_mem_stall  out  1  hold EX/MEM
- mem_wb_flush  out  1  insert bubble into MEM/WB
- bus_error  out  1  sticky, set on timeout
- stall_cnt  out  CNT_W  cycles with pc_stall=1
- flush_cnt  out  CNT_W  cycles with if_id_flush=1

## Operation
- FSM states: RUN, WAIT, ERR. Internal wait_cnt is $clog2(TIMEOUT) bits wide.
- Definitions:
  - miss = mem_req & ~mem_ready
  - mstall = miss | (state==ERR)
- Combinational (Mealy) outputs, priority mem stall > branch > load-use:
  - ex_mem_stall = id_ex_stall = mem_wb_flush = mstall
  - br = branch_taken_EX & ~mstall
  - lu = load_use_hazard & ~branch_taken_EX & ~mstall
  - pc_stall = if_id_stall = mstall | lu
  - if_id_flush = br
  - id_ex_flush = br | lu
- Branch beats load-use because the dependent instruction in ID is being flushed.
- A branch seen during a mem stall is not lost. EX is frozen, so branch_taken_EX re-presents on the release cycle and flushes then.
- Transitions:
  - RUN:
    - miss → WAIT, wait_cnt←1
    - else stay in RUN
  - WAIT:
    - ~mem_req or mem_ready → RUN, wait_cnt←0
    - else if wait_cnt==TIMEOUT-1 → ERR, bus_error←1
    - else wait_cnt←wait_cnt+1
  - ERR:
    - stays in ERR until cpu_rst
    - all pipeline stages stay frozen with mem_wb_flush=1, regardless of inputs
- Timeout rule: TIMEOUT consecutive miss cycles means the next cycle is ERR. mem_ready arriving on the TIMEOUT-th cycle returns to RUN with no error.
- Counters:
  - stall_cnt += 1 each cycle pc_stall=1
  - flush_cnt += 1 each cycle if_id_flush=1
  - both saturate at all-ones and do not wrap
  - both keep counting in ERR (stall_cnt increments every ERR cycle)
- Reset values: state=RUN, wait_cnt=0, bus_error=0, stall_cnt=0, flush_cnt=0.
- While cpu_rst=1, combinational outputs follow the RUN equations from the current inputs. Reset mid-WAIT or in ERR returns to RUN on the next edge.

## Timing
- Stall/flush outputs have zero-cycle latency from inputs, so they affect the same clock edge.
- The load-use hazard costs exactly 1 bubble. The hazard deasserts by itself once the load leaves EX, so no state is kept for it.
- A branch costs 2 flushed slots (IF/ID + ID/EX) in the same cycle.
- Memory stall length equals the number of miss cycles. Release happens on the mem_ready cycle.
- bus_error and ERR take effect on the edge after the TIMEOUT-th miss cycle.
- Counters update on the edge after the qualifying cycle.

## Test plan
- Reset, then idle inputs for 3 cycles → all outputs 0, both counters 0, bus_error 0.
- load_use_hazard=1 for 1 cycle → pc_stall=if_id_stall=id_ex_flush=1, if_id_flush=0; stall_cnt=1 next cycle.
- load_use_hazard=1 and branch_taken_EX=1 in the same cycle → if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt=1, stall_cnt=0.
- mem_req=1 with mem_ready low for 4 cycles, then high with branch_taken_EX=1 held throughout:
  - 4 cycles of mstall outputs with if_id_flush=0
  - release cycle: if_id_flush=1
  - stall_cnt=4, flush_cnt=1, state RUN
- TIMEOUT=15, mem_req=1, mem_ready=0 held:
  - bus_error=1 after 15 cycles
  - outputs stay frozen after mem_req drops
  - cpu_rst pulse → RUN, counters 0
- Boundary: mem_ready=1 on 15th miss-free-ending cycle (14 misses, then ready) → no bus_error. Force stall_cnt near all-ones (CNT_W=4 build) → saturates at 15.
